// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM encodings,
// handshake levels and the stall-vector bit positions used by the stall controller.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_BUSY   = 2'd2,
    DIV_DONE   = 2'd3
  } div_state_e;

  localparam logic        DivStart = 1'b1;
  localparam logic        DivStop  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Bit positions within the 6-bit stall vector (PC..WB).
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_DIV_PATTERN = 6'b001111;

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider handshake bundle: operands and start/annul in,
// {remainder, quotient}, ready and stall request out.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit
// into the partial remainder and trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_msb_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              qbit_o
);
  // rem_i < divisor, so the shifted value needs one extra bit but the
  // kept difference always fits back into DATA_W bits.
  logic [DATA_W:0] partial;

  assign partial = {rem_i, dvd_msb_i};
  assign qbit_o  = (partial >= {1'b0, divisor_i});
  assign rem_o   = qbit_o ? DATA_W'(partial - {1'b0, divisor_i})
                          : partial[DATA_W-1:0];
endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: latches absolute operands on start, runs
// 32 restoring steps, applies sign correction and holds the result while EX stalls.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);
  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   step_rem;
  logic                step_bit;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  // The dividend register doubles as the quotient: its MSB feeds the step
  // and the new quotient bit enters at the bottom.
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (quo_q[DATA_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_bit)
  );

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DIV_IDLE: begin
        if (bus.start_i == DivStart && !bus.annul_i) begin
          rem_d = '0;
          cnt_d = '0;
          if (bus.opdata2_i == '0) begin
            state_d   = DIV_BYZERO;
            quo_d     = '0;
            dvs_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            state_d   = DIV_BUSY;
            quo_d     = op1_abs;
            dvs_d     = op2_abs;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
          end
        end
      end
      DIV_BYZERO: begin
        state_d = bus.annul_i ? DIV_IDLE : DIV_DONE;
      end
      DIV_BUSY: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[DATA_W-2:0], step_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (bus.annul_i || bus.start_i == DivStop) begin
          state_d  = DIV_IDLE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (!ready_q) begin
          // First DONE cycle publishes the sign-corrected result; later cycles hold it.
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i && !ready_q && !bus.annul_i;
endmodule
